// File: rtl/fan_cmd_scheduler.sv
// ============================================================================
// Module      : fan_cmd_scheduler
// Description : Queues fan remote commands and replays each one REPEATS times
//               to the packet generator, with a fixed idle gap between sends.
//               Optional macro FAN_CMD_DEDUP_EN drops a command identical to
//               the newest entry still waiting in the queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_cmd_scheduler #(
    parameter int REPEATS    = 4,
    parameter int GAP_CYCLES = 20000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       ref_clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_id,
    input  logic [6:0] cmd_code,
    output logic       gen_start,
    output logic [3:0] gen_id,
    output logic [6:0] gen_cmd,
    input  logic       gen_busy,
    output logic       sched_busy,
    output logic       err_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]       REP_INIT = 4'(REPEATS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t state, next_state;

    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             init_done;
    logic [3:0]       rep_cnt;
    logic [2:0]       ack_cnt;
    logic [15:0]      gap_cnt;

    logic full, empty, push_hs, push, pop, is_dup;
    logic timeout_evt, rep_dec;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign cmd_ready  = init_done && !full;
    assign push_hs    = cmd_valid && cmd_ready;
    assign pop        = (state == LOAD);
    assign push       = push_hs && !is_dup;
    assign sched_busy = (state != IDLE);

`ifdef FAN_CMD_DEDUP_EN
    logic [PTR_W-1:0] last_ptr;
    logic [10:0]      last_entry;
    logic             last_present;

    // The newest entry stays queued unless it is the only one and leaves now.
    assign last_ptr     = PTR_W'(wr_ptr - 1'b1);
    assign last_entry   = mem[last_ptr];
    assign last_present = !empty && !(pop && (count == CNT_W'(1)));
    assign is_dup       = last_present && (last_entry == {cmd_id, cmd_code});
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge ref_clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_id, cmd_code};
        end
    end

    always_comb begin
        next_state  = state;
        gen_start   = 1'b0;
        timeout_evt = 1'b0;
        rep_dec     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) next_state = LOAD;
            end
            LOAD: begin
                next_state = START;
            end
            START: begin
                gen_start  = 1'b1;
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (gen_busy) begin
                    next_state = WAIT_DONE;
                end else if (ack_cnt == 3'd7) begin
                    timeout_evt = 1'b1;
                    rep_dec     = 1'b1;
                    next_state  = GAP;
                end
            end
            WAIT_DONE: begin
                if (!gen_busy) begin
                    rep_dec    = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (rep_cnt != 4'd0) next_state = START;
                    else if (empty)      next_state = IDLE;
                    else                 next_state = LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            init_done   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            gen_id      <= 4'd0;
            gen_cmd     <= 7'd0;
            rep_cnt     <= 4'd0;
            ack_cnt     <= 3'd0;
            gap_cnt     <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            state     <= next_state;
            init_done <= 1'b1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (state == LOAD) begin
                {gen_id, gen_cmd} <= mem[rd_ptr];
                rep_cnt           <= REP_INIT;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - 4'd1;
            end

            ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 3'd1 : 3'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

            if (timeout_evt) err_timeout <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fan_cmd_scheduler.sv
// ============================================================================
// Module      : tb_fan_cmd_scheduler
// Description : Scoreboard bench for fan_cmd_scheduler with a generator model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fan_cmd_scheduler;

    localparam int REPEATS = 4;
    localparam int GAP     = 40;
    localparam int DEPTH   = 4;
`ifdef FAN_CMD_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic       ref_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_id = 4'd0;
    logic [6:0] cmd_code = 7'd0;
    logic       gen_busy = 1'b0;
    logic       cmd_ready, gen_start, sched_busy, err_timeout;
    logic [3:0] gen_id;
    logic [6:0] gen_cmd;

    fan_cmd_scheduler #(
        .REPEATS    (REPEATS),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ref_clk     (ref_clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_id      (cmd_id),
        .cmd_code    (cmd_code),
        .gen_start   (gen_start),
        .gen_id      (gen_id),
        .gen_cmd     (gen_cmd),
        .gen_busy    (gen_busy),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout)
    );

    always #5 ref_clk = ~ref_clk;

    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          gen_mode = 1;
    int          busy_len = 5;
    logic [10:0] sb[$];
    int          start_edges[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Generator model: acknowledges a start with busy_len cycles of gen_busy.
    initial begin
        forever begin
            @(negedge ref_clk);
            if (gen_start === 1'b1 && gen_mode == 1) begin
                @(posedge ref_clk);
                #1 gen_busy = 1'b1;
                repeat (busy_len) @(posedge ref_clk);
                #1 gen_busy = 1'b0;
            end
        end
    end

    // Each start is recorded with the index of the edge that captures it.
    always @(negedge ref_clk) begin
        if (gen_start === 1'b1) begin
            start_edges.push_back(cyc + 1);
            if (sb.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("start_payload", {21'd0, gen_id, gen_cmd}, {21'd0, sb.pop_front()});
            end
        end
    end

    task automatic push_cmd(input logic [3:0] id, input logic [6:0] code,
                            input logic exp_acc, input logic exp_enq, output int edge_no);
        @(negedge ref_clk);
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_code  = code;
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_acc});
        if (exp_enq) begin
            for (int r = 0; r < REPEATS; r++) sb.push_back({id, code});
        end
        edge_no = cyc + 1;
        @(posedge ref_clk);
    endtask

    task automatic release_valid();
        @(negedge ref_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int bound);
        int k = 0;
        while (start_edges.size() < n && k < bound) begin
            @(negedge ref_clk);
            k++;
        end
        check("start_seen", {31'd0, start_edges.size() >= n}, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (sched_busy !== 1'b0 && k < bound) begin
            @(negedge ref_clk);
            k++;
        end
        check("reach_idle", {31'd0, sched_busy}, 32'd0);
    endtask

    task automatic wait_gen_busy(input int bound);
        int k = 0;
        while (gen_busy !== 1'b1 && k < bound) begin
            @(negedge ref_clk);
            k++;
        end
        check("gen_busy_seen", {31'd0, gen_busy}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_gen_start",   {31'd0, gen_start},   32'd0);
        check("rst_gen_id",      {28'd0, gen_id},      32'd0);
        check("rst_gen_cmd",     {25'd0, gen_cmd},     32'd0);
        check("rst_sched_busy",  {31'd0, sched_busy},  32'd0);
        check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        check("rst_cmd_ready",   {31'd0, cmd_ready},   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pe, b, e, n;

        // Power-on reset
        #1 check_reset_outputs();
        repeat (2) @(posedge ref_clk);
        @(negedge ref_clk) reset_n = 1'b1;
        @(negedge ref_clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Single command: latency, repeat count, spacing, end of busy
        busy_len = 5;
        b = start_edges.size();
        push_cmd(4'hA, 7'h17, 1'b1, 1'b1, pe);
        release_valid();
        wait_starts(b + 1, 50);
        check("first_start_latency", start_edges[b] - pe, 32'd3);
        wait_idle(1000);
        check("start_count", start_edges.size() - b, REPEATS);
        if (start_edges.size() >= b + 4) begin
            for (int i = 1; i < 4; i++)
                check("start_spacing", start_edges[b+i] - start_edges[b+i-1], busy_len + GAP + 2);
            check("busy_fall", cyc - start_edges[b+3], busy_len + GAP + 1);
        end

        // Queue fills while the generator is held busy
        busy_len = 60;
        b = start_edges.size();
        push_cmd(4'h1, 7'h01, 1'b1, 1'b1, pe);
        release_valid();
        wait_gen_busy(50);
        for (int i = 0; i < 5; i++)
            push_cmd(4'(i + 2), 7'(i + 2), i < 4, i < 4, pe);
        release_valid();
        busy_len = 5;
        wait_idle(3000);
        check("sb_drained_fill", sb.size(), 32'd0);
        check("fill_start_count", start_edges.size() - b, 5 * REPEATS);
        check("no_timeout_yet", {31'd0, err_timeout}, 32'd0);

        // Generator never acknowledges
        gen_mode = 0;
        b = start_edges.size();
        push_cmd(4'h3, 7'h05, 1'b1, 1'b1, pe);
        release_valid();
        wait_starts(b + 1, 50);
        e = start_edges[b];
        while (cyc < e + 7) @(negedge ref_clk);
        check("timeout_not_yet", {31'd0, err_timeout}, 32'd0);
        @(negedge ref_clk);
        check("timeout_set", {31'd0, err_timeout}, 32'd1);
        wait_idle(1000);
        check("timeout_start_count", start_edges.size() - b, REPEATS);
        if (start_edges.size() >= b + 2)
            check("timeout_spacing", start_edges[b+1] - e, GAP + 9);
        check("timeout_sticky", {31'd0, err_timeout}, 32'd1);
        gen_mode = 1;

        // Identical back-to-back command while busy
        busy_len = 60;
        b = start_edges.size();
        push_cmd(4'h7, 7'h11, 1'b1, 1'b1, pe);
        release_valid();
        wait_gen_busy(50);
        push_cmd(4'hA, 7'h17, 1'b1, 1'b1, pe);
        push_cmd(4'hA, 7'h17, 1'b1, !DEDUP, pe);
        release_valid();
        busy_len = 5;
        wait_idle(3000);
        check("sb_drained_dup", sb.size(), 32'd0);
        check("dup_start_count", start_edges.size() - b, DEDUP ? 2 * REPEATS : 3 * REPEATS);

        // Reset while waiting for the generator to finish
        busy_len = 40;
        push_cmd(4'hC, 7'h2A, 1'b1, 1'b1, pe);
        release_valid();
        wait_gen_busy(50);
        @(negedge ref_clk);
        @(negedge ref_clk);
        check("in_wait_done", {31'd0, sched_busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        repeat (2) @(posedge ref_clk);
        @(negedge ref_clk) reset_n = 1'b1;
        n = start_edges.size();
        repeat (100) @(negedge ref_clk);
        check("no_start_after_reset", start_edges.size(), n);
        check("idle_after_reset", {31'd0, sched_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
